// File: rtl/matrix_scan_sched.sv
// Row-scan scheduler for an 8x8 red/green LED matrix with a double-buffered frame store.
// Define PEN_SENSE_EN to add the per-row light-pen sense window and hit reporting.
module matrix_scan_sched #(
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned SENSE_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic       pen_in,
  output logic [7:0] output_row,
  output logic [7:0] output_col_r,
  output logic [7:0] output_col_g,
  output logic       pen_valid,
  output logic [2:0] pen_x,
  output logic [2:0] pen_y,
  output logic       frame_tick
);
  localparam int unsigned MaxBd  = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int unsigned MaxLen = (MaxBd > SENSE_CYCLES) ? MaxBd : SENSE_CYCLES;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {StBlank, StDrive, StSense} state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            row_last;
  logic            frame_last_d;
  logic [7:0]      row_sel_d, col_r_d, col_g_d;
  logic [7:0]      back_r_q [8];
  logic [7:0]      back_g_q [8];
  logic [7:0]      front_r_q [8];
  logic [7:0]      front_g_q [8];

`ifdef PEN_SENSE_EN
  localparam logic [CntW-1:0] SenseLast = CntW'(SENSE_CYCLES - 1);
  logic [2:0] col_q, col_d;
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q + 1'b1;
    row_last = 1'b0;
`ifdef PEN_SENSE_EN
    col_d    = col_q;
`endif
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StDrive;
          cnt_d   = '0;
        end
      end
      StDrive: begin
        if (cnt_q == DwellLast) begin
          cnt_d = '0;
`ifdef PEN_SENSE_EN
          state_d = StSense;
          col_d   = 3'd0;
`else
          state_d  = StBlank;
          row_d    = row_q + 3'd1;
          row_last = 1'b1;
`endif
        end
      end
`ifdef PEN_SENSE_EN
      StSense: begin
        if (cnt_q == SenseLast) begin
          cnt_d = '0;
          col_d = col_q + 3'd1;
          if (col_q == 3'd7) begin
            state_d  = StBlank;
            row_d    = row_q + 3'd1;
            row_last = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins and frame_tick are derived from the next state so they line up with the state itself.
  always_comb begin
    row_sel_d = 8'hFF;
    col_r_d   = 8'h00;
    col_g_d   = 8'h00;
    if (state_d == StDrive) begin
      row_sel_d = ~(8'd1 << row_d);
      col_r_d   = front_r_q[row_d];
      col_g_d   = front_g_q[row_d];
    end
`ifdef PEN_SENSE_EN
    if (state_d == StSense) begin
      row_sel_d = ~(8'd1 << row_d);
      col_r_d   = 8'd1 << col_d;
    end
    frame_last_d = (state_d == StSense) && (col_d == 3'd7) && (cnt_d == SenseLast) &&
                   (row_d == 3'd7);
`else
    frame_last_d = (state_d == StDrive) && (cnt_d == DwellLast) && (row_d == 3'd7);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StBlank;
      row_q        <= '0;
      cnt_q        <= '0;
      output_row   <= 8'hFF;
      output_col_r <= '0;
      output_col_g <= '0;
      frame_tick   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        back_r_q[i]  <= '0;
        back_g_q[i]  <= '0;
        front_r_q[i] <= '0;
        front_g_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      output_row   <= row_sel_d;
      output_col_r <= col_r_d;
      output_col_g <= col_g_d;
      frame_tick   <= frame_last_d;
      if (wr_en) begin
        back_r_q[wr_row] <= wr_r;
        back_g_q[wr_row] <= wr_g;
      end
      // Commit includes a write landing in the same cycle.
      if (frame_tick) begin
        for (int i = 0; i < 8; i++) begin
          front_r_q[i] <= (wr_en && wr_row == 3'(i)) ? wr_r : back_r_q[i];
          front_g_q[i] <= (wr_en && wr_row == 3'(i)) ? wr_g : back_g_q[i];
        end
      end
    end
  end

`ifdef PEN_SENSE_EN
  logic       pen_meta_q, pen_sync_q;
  logic       hit_q;
  logic [2:0] hit_col_q;
  logic       sample;

  assign sample = (state_q == StSense) && (cnt_q == SenseLast) && pen_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pen_meta_q <= 1'b0;
      pen_sync_q <= 1'b0;
      col_q      <= '0;
      hit_q      <= 1'b0;
      hit_col_q  <= '0;
      pen_valid  <= 1'b0;
      pen_x      <= '0;
      pen_y      <= '0;
    end else begin
      pen_meta_q <= pen_in;
      pen_sync_q <= pen_meta_q;
      col_q      <= col_d;
      pen_valid  <= 1'b0;
      if (row_last) begin
        hit_q <= 1'b0;
        if (hit_q || sample) begin
          pen_valid <= 1'b1;
          pen_x     <= hit_q ? hit_col_q : col_q;
          pen_y     <= row_q;
        end
      end else if (sample && !hit_q) begin
        hit_q     <= 1'b1;
        hit_col_q <= col_q;
      end
    end
  end
`else
  logic unused_pen_in;
  assign unused_pen_in = pen_in;
  assign pen_valid     = 1'b0;
  assign pen_x         = 3'd0;
  assign pen_y         = 3'd0;
`endif

endmodule
